scope_capture_streamer: RTL and testbench
=========================================

Name: scope_capture_streamer

Overview:
- Upstream feeder for the UART transmitter. Accepts a stream of 8-bit ADC samples and arms on request.
- On a rising-edge level trigger, captures DEPTH consecutive samples into an internal buffer.
- Streams a framed packet byte-by-byte: header 0xA5, header 0x5A, length byte, then samples.
- Drives the transmitter's dataOut and active-low sendOnLow, pacing each byte to cover the transmitter's frame time plus its post-send debounce wait.

Parameters:
- DEPTH, 64: samples per capture; power of two, 2..256.
- BYTE_GAP, 265000: clk cycles from one send request to the next. Must exceed 10*DELAY_FRAMES + 262144 of the downstream transmitter.
- PULSE_LEN, 4: clk cycles sendOnLow is held low per byte; 1 <= PULSE_LEN < BYTE_GAP.

Ports:
- clk  in  1  system clock (27 MHz)
- rst_n  in  1  asynchronous active-low reset
- adc_data  in  8  ADC sample
- adc_valid  in  1  one-cycle qualifier for adc_data
- trig_level  in  8  trigger threshold, unsigned
- arm  in  1  level; a high seen in IDLE starts a capture
- force_trig  in  1  level; in ARMED, triggers on the next valid sample regardless of level
- dataOut  out  8  byte to transmitter
- sendOnLow  out  1  active-low send request to transmitter
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the last packet byte's gap expires

Behaviour:
- Reset (async, rst_n low) values: state IDLE, dataOut 0, sendOnLow 1, busy 0, done 0. Write pointer, read index, gap counter and prev_sample all 0. Buffer contents are undefined.
- Reset mid-stream: sendOnLow returns to 1 immediately; the packet is abandoned.
- States: IDLE, ARMED, CAPTURE, SEND, GAP.
- IDLE -> ARMED when arm=1. prev_sample is cleared, and the first valid sample in ARMED only loads prev_sample; it cannot trigger.
- ARMED:
  - On each adc_valid, the trigger condition is (prev_sample < trig_level and adc_data >= trig_level) or force_trig=1.
  - On trigger, that sample is written to buffer[0] and the block moves to CAPTURE with wr_ptr=1. Otherwise prev_sample <= adc_data.
  - Special case: when DEPTH==... not applicable, since DEPTH >= 2.
- CAPTURE: each adc_valid writes buffer[wr_ptr] and increments wr_ptr. The write of index DEPTH-1 moves to SEND with byte_idx=0. Cycles without adc_valid are ignored.
- Packet byte sequence:
  - idx 0 = 0xA5
  - idx 1 = 0x5A
  - idx 2 = (DEPTH-1) truncated to 8 bits
  - idx 3..DEPTH+2 = buffer[idx-3]
  - Total DEPTH+3 bytes.
- SEND:
  - On entry, dataOut <= byte[idx] and sendOnLow <= 0 on the same edge; gap_cnt starts at 0.
  - sendOnLow stays 0 for exactly PULSE_LEN cycles, then goes to 1 and the state moves to GAP.
  - dataOut is held constant from entry until the next byte is loaded.
- GAP:
  - gap_cnt continues counting. When gap_cnt reaches BYTE_GAP-1, the state changes.
  - If idx == DEPTH+2: done=1 for one cycle, then IDLE.
  - Otherwise idx++ and SEND.
  - Consecutive sendOnLow falling edges are therefore exactly BYTE_GAP cycles apart.
- arm, force_trig and trig_level are ignored outside IDLE/ARMED. Samples arriving during SEND/GAP are dropped.
- arm held high continuously re-arms immediately after done (IDLE for 1 cycle).
- gap_cnt width is clog2(BYTE_GAP)+1. All comparisons are unsigned.

Test Plan:
(Bench parameters: DEPTH=4, BYTE_GAP=20, PULSE_LEN=2.)
- Reset check: assert rst_n=0 mid-GAP -> same-cycle sendOnLow=1, busy=0, dataOut=0; after release the block stays IDLE with no sendOnLow activity.
- Level trigger: trig_level=0x80, arm=1, valid samples 0x10,0x70,0x90,0xA0,0xB0,0xC0 -> trigger at 0x90.
  - dataOut sequence: A5,5A,03,90,A0,B0,C0.
  - sendOnLow low for 2 cycles per byte, falling edges 20 cycles apart.
  - done pulses once, 140 cycles after the first falling edge.
- No false trigger: first valid sample in ARMED is 0xFF with level 0x80, followed by 0xFF,0xFF -> stays ARMED. Then 0x00 followed by 0x81 -> triggers on 0x81.
- Sparse valid: adc_valid every 3rd cycle during CAPTURE -> exactly 4 samples are captured with no duplicates, and sampling stops after the fourth.
- force_trig: force_trig=1 with flat input 0x20 -> capture starts on the next valid sample, payload 20,20,20,20.
- Continuous arm: arm tied high -> one cycle after done, busy=1 again in ARMED. No sendOnLow activity until the next trigger.

Source files
------------

// File: rtl/scope_capture_streamer.sv
// Captures a triggered burst of ADC samples and streams it as a framed packet
// (A5, 5A, length, samples) to a UART transmitter, one paced byte at a time.
module scope_capture_streamer #(
  parameter int DEPTH     = 64,
  parameter int BYTE_GAP  = 265000,
  parameter int PULSE_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] adc_data,
  input  logic       adc_valid,
  input  logic [7:0] trig_level,
  input  logic       arm,
  input  logic       force_trig,
  output logic [7:0] dataOut,
  output logic       sendOnLow,
  output logic       busy,
  output logic       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(BYTE_GAP) + 1;
  localparam int IW = 9;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH + 2);
  localparam logic [7:0]    LEN_BYTE = 8'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_WR  = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_SEND,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          sol_q, sol_d;
  logic          done_q, done_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    prev_q, prev_d;
  logic          seen_q, seen_d;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_q;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] rd_addr;
  logic [7:0]    next_byte;
  logic          trig_hit;

  // Prefetch the payload byte for idx_q+1; SEND plus GAP always span at
  // least two edges, so rd_q is settled before the next byte is loaded.
  assign rd_addr = AW'(idx_q - IW'(2));

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= adc_data;
    end
    rd_q <= mem[rd_addr];
  end

  always_comb begin
    next_byte = rd_q;
    case (idx_q)
      IW'(0):  next_byte = 8'h5A;
      IW'(1):  next_byte = LEN_BYTE;
      default: next_byte = rd_q;
    endcase
  end

  // The first sample after arming only seeds prev_q, so a stale zero can
  // never fake a rising crossing.
  assign trig_hit = seen_q &&
                    (((prev_q < trig_level) && (adc_data >= trig_level)) || force_trig);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sol_d    = sol_q;
    done_d   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    prev_d   = prev_q;
    seen_d   = seen_q;
    we       = 1'b0;
    waddr    = wr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_ARMED;
          prev_d  = 8'h00;
          seen_d  = 1'b0;
        end
      end
      S_ARMED: begin
        if (adc_valid) begin
          if (trig_hit) begin
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_d = AW'(1);
            state_d  = S_CAPTURE;
          end else begin
            prev_d = adc_data;
            seen_d = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        if (adc_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (wr_ptr_q == LAST_WR) begin
            state_d = S_SEND;
            idx_d   = '0;
            data_d  = 8'hA5;
            sol_d   = 1'b0;
            gap_d   = '0;
          end
        end
      end
      S_SEND: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(PULSE_LEN - 1)) begin
          sol_d   = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(BYTE_GAP - 1)) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            data_d  = next_byte;
            sol_d   = 1'b0;
            gap_d   = '0;
            state_d = S_SEND;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      data_q   <= 8'h00;
      sol_q    <= 1'b1;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      prev_q   <= 8'h00;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sol_q    <= sol_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      prev_q   <= prev_d;
      seen_q   <= seen_d;
    end
  end

  assign dataOut   = data_q;
  assign sendOnLow = sol_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_scope_capture_streamer.sv
// Directed bench: table of capture scenarios with expected packets, plus
// hand sequences for continuous re-arm and mid-packet reset.
module tb_scope_capture_streamer;

  localparam int DEPTH     = 4;
  localparam int BYTE_GAP  = 20;
  localparam int PULSE_LEN = 2;
  localparam int NBYTES    = DEPTH + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic [7:0] trig_level;
  logic       arm;
  logic       force_trig;
  logic [7:0] dataOut;
  logic       sendOnLow;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  scope_capture_streamer #(
    .DEPTH    (DEPTH),
    .BYTE_GAP (BYTE_GAP),
    .PULSE_LEN(PULSE_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .trig_level(trig_level),
    .arm       (arm),
    .force_trig(force_trig),
    .dataOut   (dataOut),
    .sendOnLow (sendOnLow),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    string      name;
    logic [7:0] level;
    logic       frc;
    int         nsamp;
    logic [7:0] samp [8];
    int         spacing;
    logic [7:0] pay  [4];
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_pkt [NBYTES];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_arm(input int vi, input logic hold);
    trig_level = vecs[vi].level;
    force_trig = vecs[vi].frc;
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 if (!hold) arm = 1'b0;
    @(negedge clk);
    chk({vecs[vi].name, "_armed_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic drive(input int vi);
    for (int i = 0; i < vecs[vi].nsamp; i++) begin
      adc_data  = vecs[vi].samp[i];
      adc_valid = 1'b1;
      @(posedge clk); #1 adc_valid = 1'b0;
      for (int k = 1; k < vecs[vi].spacing; k++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic monitor(input string name, input logic busy_after);
    int         cyc = 0;
    int         nf = 0;
    int         ndone = 0;
    int         done_cyc = 0;
    int         fall [8];
    int         lowc [8];
    logic [7:0] bytes [8];
    logic       prev = 1'b1;
    logic       stable_ok = 1'b1;
    while (cyc < 400 && ndone == 0) begin
      @(negedge clk);
      cyc++;
      if (sendOnLow == 1'b0) begin
        if (prev == 1'b1 && nf < 8) begin
          fall[nf]  = cyc;
          bytes[nf] = dataOut;
          lowc[nf]  = 0;
          nf++;
        end
        if (nf > 0) lowc[nf-1]++;
      end
      if (nf > 0 && dataOut !== bytes[nf-1]) stable_ok = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        done_cyc = cyc;
      end
      prev = sendOnLow;
    end
    chk({name, "_nbytes"}, 32'(nf), 32'(NBYTES));
    for (int i = 0; i < NBYTES; i++) begin
      if (i < nf) begin
        chk($sformatf("%s_byte%0d", name, i), 32'(bytes[i]), 32'(exp_pkt[i]));
        chk($sformatf("%s_low%0d", name, i), 32'(lowc[i]), 32'(PULSE_LEN));
        if (i > 0) chk($sformatf("%s_gap%0d", name, i), 32'(fall[i] - fall[i-1]), 32'(BYTE_GAP));
      end
    end
    chk({name, "_dataout_stable"}, 32'(stable_ok), 32'd1);
    chk({name, "_done_seen"}, 32'(ndone), 32'd1);
    if (nf > 0 && ndone > 0)
      chk({name, "_done_time"}, 32'(done_cyc - fall[0]), 32'(NBYTES * BYTE_GAP));
    @(negedge clk);
    chk({name, "_done_onecycle"}, 32'(done), 32'd0);
    chk({name, "_busy_after"}, 32'(busy), 32'(busy_after));
  endtask

  task automatic set_exp(input int vi);
    exp_pkt[0] = 8'hA5;
    exp_pkt[1] = 8'h5A;
    exp_pkt[2] = 8'(DEPTH - 1);
    for (int i = 0; i < DEPTH; i++) exp_pkt[i+3] = vecs[vi].pay[i];
  endtask

  initial begin
    int lows;
    int busys;

    vecs[0] = '{"level", 8'h80, 1'b0, 6,
                '{8'h10, 8'h70, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'h00, 8'h00}, 1,
                '{8'h90, 8'hA0, 8'hB0, 8'hC0}};
    vecs[1] = '{"nofalse", 8'h80, 1'b0, 8,
                '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h81, 8'h11, 8'h22, 8'h33}, 1,
                '{8'h81, 8'h11, 8'h22, 8'h33}};
    vecs[2] = '{"sparse", 8'h80, 1'b0, 7,
                '{8'h10, 8'h90, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h00}, 3,
                '{8'h90, 8'h91, 8'h92, 8'h93}};
    vecs[3] = '{"force", 8'h80, 1'b1, 7,
                '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h00}, 1,
                '{8'h20, 8'h20, 8'h20, 8'h20}};
    vecs[4] = '{"contarm", 8'h80, 1'b0, 5,
                '{8'h10, 8'h90, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00}, 1,
                '{8'h90, 8'h01, 8'h02, 8'h03}};
    vecs[5] = vecs[4];

    rst_n      = 1'b0;
    adc_data   = 8'h00;
    adc_valid  = 1'b0;
    trig_level = 8'h00;
    arm        = 1'b0;
    force_trig = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dataOut", 32'(dataOut), 32'h0);
    chk("reset_sendOnLow", 32'(sendOnLow), 32'h1);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      set_exp(v);
      start_arm(v, 1'b0);
      fork
        drive(v);
        monitor(vecs[v].name, 1'b0);
      join
      force_trig = 1'b0;
      $display("vector %s: packet checked, %0d miscompares so far", vecs[v].name, n_err);
      repeat (3) @(negedge clk);
    end

    // Continuous arm: IDLE for exactly the done cycle, then ARMED with no sends.
    set_exp(4);
    start_arm(4, 1'b1);
    fork
      drive(4);
      monitor("contarm", 1'b1);
    join
    lows  = 0;
    busys = 0;
    repeat (30) begin
      @(negedge clk);
      if (sendOnLow == 1'b0) lows++;
      if (busy == 1'b1) busys++;
    end
    chk("contarm_quiet_sendOnLow", 32'(lows), 32'd0);
    chk("contarm_stays_armed", 32'(busys), 32'd30);
    $display("sequence contarm: checked, %0d miscompares so far", n_err);

    // Reset mid-GAP: outputs must drop to reset values without a clock edge.
    drive(5);
    repeat (5) @(negedge clk);
    chk("midgap_sendOnLow", 32'(sendOnLow), 32'h1);
    chk("midgap_busy", 32'(busy), 32'h1);
    chk("midgap_dataOut", 32'(dataOut), 32'hA5);
    arm = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("asyncrst_sendOnLow", 32'(sendOnLow), 32'h1);
    chk("asyncrst_busy", 32'(busy), 32'h0);
    chk("asyncrst_dataOut", 32'(dataOut), 32'h0);
    chk("asyncrst_done", 32'(done), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    lows  = 0;
    busys = 0;
    repeat (40) begin
      @(negedge clk);
      if (sendOnLow == 1'b0) lows++;
      if (busy == 1'b1) busys++;
    end
    chk("postrst_sendOnLow", 32'(lows), 32'd0);
    chk("postrst_idle", 32'(busys), 32'd0);
    $display("sequence midreset: checked, %0d miscompares so far", n_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
